// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, IF/ID register.
// Handles stall/flush and execute redirects, dropping stale in-flight responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pcf_n;
  logic [31:0] reqpc;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        stall;
  logic        deliver;
  logic        buf_wr;
  logic        new_req;
  logic [31:0] dinstr;
  logic [31:0] dpc;

  assign imem_addr = reqpc;

  always_comb begin
    stall    = StallF | StallD;
    state_n  = state;
    pcf_n    = PCF;
    deliver  = 1'b0;
    buf_wr   = 1'b0;
    dinstr   = imem_rdata;
    dpc      = PCF;
    imem_req = 1'b0;
    unique case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          if (PCSrcE) begin
            pcf_n = PCTargetE;
          end else if (!stall) begin
            deliver = 1'b1;
            pcf_n   = PCF + 32'd4;
          end else begin
            buf_wr  = 1'b1;
            state_n = HOLD;
          end
        end else if (PCSrcE) begin
          pcf_n   = PCTargetE;
          state_n = DRAIN;
        end
      end
      HOLD: begin
        dinstr = hold_instr;
        dpc    = hold_pc;
        if (PCSrcE) begin
          pcf_n   = PCTargetE;
          state_n = FETCH;
        end else if (!stall) begin
          deliver = 1'b1;
          pcf_n   = PCF + 32'd4;
          state_n = FETCH;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (PCSrcE) pcf_n = PCTargetE;
        if (imem_valid) state_n = FETCH;
      end
      default: state_n = FETCH;
    endcase
    if (rst) imem_req = 1'b0;
  end

  // a fresh request latches the PC it will fetch from
  assign new_req = (state_n == FETCH) &&
                   ((state == HOLD) || imem_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      PCF        <= RESET_PC;
      reqpc      <= RESET_PC;
      hold_instr <= NOP_INSTR;
      hold_pc    <= RESET_PC;
    end else begin
      state <= state_n;
      PCF   <= pcf_n;
      if (new_req) reqpc <= pcf_n;
      if (buf_wr) begin
        hold_instr <= imem_rdata;
        hold_pc    <= PCF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (StallD) begin
      InstrD   <= InstrD;
    end else if (deliver) begin
      InstrD   <= dinstr;
      PCD      <= dpc;
      PCPlus4D <= dpc + 32'd4;
      ValidD   <= 1'b1;
    end else begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined core, directly upstream of decode.
- Holds the PC and issues single-outstanding requests to a variable-latency instruction memory.
- Drives the IF/ID pipeline register (InstrD, PCD, PCPlus4D, ValidD) consumed by decode.
- Handles hazard-unit stalls and flushes, and execute-stage branch/jump redirects, including discarding in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
StallF  input  1  hazard unit: hold PC
StallD  input  1  hazard unit: hold IF/ID register
FlushD  input  1  hazard unit: bubble IF/ID register
PCSrcE  input  1  execute: redirect taken
PCTargetE  input  32  execute: redirect target
imem_req  output  1  fetch request, held until imem_valid
imem_addr  output  32  fetch address, stable while imem_req high
imem_rdata  input  32  fetched instruction, qualified by imem_valid
imem_valid  input  1  one-cycle response strobe, exactly one per request; may arrive in the first cycle of a request (zero-wait)
PCF  output  32  current fetch PC
InstrD  output  32  IF/ID instruction
PCD  output  32  IF/ID PC
PCPlus4D  output  32  IF/ID PC+4
ValidD  output  1  IF/ID holds a real instruction

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Everything updates on the rising clk edge only.
- Reset values:
  - PCF=RESET_PC, state=FETCH.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - imem_req=0 in any cycle rst is high.
- Definitions:
  - stall = StallF | StallD.
  - "deliver" = a captured or buffered instruction is written into IF/ID with PCD=its PC, PCPlus4D=PC+4 (mod 2^32), ValidD=1.
- Internal registers: ReqPC (address of the outstanding request) and a one-entry hold buffer (instruction and PC).
- imem_addr=ReqPC. ReqPC tracks PCF whenever a new request begins.
- States:
  - FETCH: imem_req=1.
    - No imem_valid: hold. If PCSrcE, go to DRAIN.
    - imem_valid with PCSrcE: discard the response, PCF<=PCTargetE, stay in FETCH (new request next cycle).
    - imem_valid, no redirect, !stall: deliver, PCF<=PCF+4, stay in FETCH. Zero-wait memory gives 1 instr/cycle.
    - imem_valid, no redirect, stall: write the hold buffer, go to HOLD. PCF is unchanged until delivery.
  - HOLD: imem_req=0.
    - PCSrcE: drop the buffer, PCF<=PCTargetE, go to FETCH.
    - Else if !stall: deliver the buffer, PCF<=PCF+4, go to FETCH.
  - DRAIN: imem_req=1 with the old ReqPC, held until imem_valid.
    - PCF<=PCTargetE on each redirect; the latest target wins.
    - On imem_valid: discard the response, go to FETCH at PCF.
- IF/ID register update priority, highest first:
  1. rst
  2. FlushD: bubble (InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0)
  3. StallD: hold all IF/ID outputs
  4. deliver
  5. otherwise: bubble (covers waiting, draining, and redirect cycles)
- FlushD never affects PCF or state. A redirect alone does not flush IF/ID; the hazard unit asserts FlushD with PCSrcE.
- StallF without StallD: PC held. IF/ID takes a bubble unless FlushD; the instruction stays in HOLD.
- PC wrap: 32'hFFFF_FFFC+4 = 0, no flag.
- Reset mid-request: state and registers reset immediately. An imem_valid arriving in the reset cycle or later for the aborted request is ignored only if it falls in the reset cycle; the memory contract requires the memory to be reset with the core.
- imem_req/imem_addr are never changed while a response is pending; this is a checkable assertion.

Test Plan:
1. Zero-wait memory returning 0x00A00093 @0, 0x00100113 @4 -> first cycle after reset: imem_addr=0. Next cycles: InstrD=0x00A00093/PCD=0/PCPlus4D=4, then 0x00100113/PCD=4, ValidD=1. PCF reaches 8.
2. Memory latency 3 -> imem_req held with imem_addr=0 for 3 cycles. IF/ID bubble (InstrD=0x13, ValidD=0) for 2 cycles, then the instruction is delivered.
3. StallD=1 for 2 cycles while the response arrives -> HOLD, imem_req=0, IF/ID unchanged. Buffered instruction delivered the cycle after StallD falls; PCF then advances by 4.
4. PCSrcE=1, PCTargetE=0x100, FlushD=1 while a latency-3 request to 0x8 is pending -> IF/ID bubble. imem_addr stays 0x8 until valid, and that response is discarded. Next request has imem_addr=0x100 and delivers with PCD=0x100.
5. FlushD and StallD both high -> IF/ID bubble (flush wins). PCF unchanged by FlushD.
6. rst asserted mid-HOLD -> next cycle PCF=RESET_PC, ValidD=0, InstrD=0x13, imem_req=0. Fetch restarts from RESET_PC.
